add_rc_slice_stage: RTL
=======================

Name: add_rc_slice_stage

Overview:
- Round-constant (iota) application stage of the encoder datapath, directly downstream of the round-constant file reader.
- Per round, it requests the round's 25-bit RC mask from the reader and registers it.
- It then walks every state slice in slice memory and writes back slice XOR mask, one slice per cycle.
- The round controller drives it with a start/done handshake.

Parameters:
- N, 25, slice width in bits; must match the reader's line width.
- SLICES, 64, number of slices per state; slice addresses 0..SLICES-1.
- ROUNDS, 24, number of valid rounds; legal round indices are 0..ROUNDS-1.
- AW, 6, slice address width; requires 2^AW >= SLICES.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, single-cycle request to process one round.
- round, input, 5, round index; sampled only on an accepted start.
- rc_in, input, N, RC mask from the reader's pout.
- rc_ld, output, 1, load strobe to the reader (its ld).
- rc_line, output, 7, line number to the reader, 1-based: round+1.
- rc_en_cnt, output, 1, counter enable to the reader; high in RUN.
- slice_addr, output, AW, slice memory address for both read and write.
- slice_in, input, N, slice memory read data; asynchronous read at slice_addr.
- slice_out, output, N, write data: slice_in ^ rc_reg.
- slice_we, output, 1, slice memory write enable.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, high with done when the round was illegal.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE.
  - rc_ld, rc_en_cnt, slice_we, busy, done, err are all 0.
  - slice_addr, rc_line, and internal rc_reg and round_reg are all 0.
  - A reset mid-RUN aborts immediately; slices already written stay written, and no further writes occur.
- IDLE:
  - start=1 with round<ROUNDS: latch round_reg and go to LOAD.
  - start=1 with round>=ROUNDS: go to DONE with err set.
  - start=0: remain in IDLE.
- LOAD (1 cycle): rc_ld=1, rc_line=round_reg+1. Go to WAIT.
  - The reader updates pout on the edge ending LOAD.
- WAIT (1 cycle): rc_reg <= rc_in on the edge ending WAIT; slice_addr=0. Go to RUN.
- RUN (SLICES cycles):
  - slice_we=1, rc_en_cnt=1, slice_out=slice_in^rc_reg (combinational).
  - slice_addr increments each cycle.
  - When slice_addr==SLICES-1, the write happens that cycle, then go to DONE with slice_addr returned to 0.
  - slice_addr never exceeds SLICES-1; there is no wrap inside RUN.
- DONE (1 cycle): done=1; err=1 only if entered from the illegal-round path. Go to IDLE. busy=1 in DONE.
- Latency:
  - Legal start to done: SLICES+3 cycles (LOAD, WAIT, SLICES RUN cycles, DONE).
  - Illegal start to done: 1 cycle.
- start while busy is ignored: no queueing and no restart.
- start asserted in the same cycle that DONE returns to IDLE is ignored. It is accepted only when sampled in IDLE.
- rc_line and rc_ld are valid only in LOAD; rc_line holds its value outside LOAD.
- Width rule: the XOR is exactly N bits with no extension; round+1 is computed in 7 bits.
- rc_reg holds across rounds until the next WAIT.

Test Plan:
- Reset mid-RUN:
  - Stimulus: assert rst asynchronously at slice_addr=10 during a round.
  - Response: all outputs 0 within the same cycle; later start round=3 runs a full round normally.
- Round 0, all-zero slices, reader line 1 = 0x0000001:
  - rc_ld one cycle with rc_line=1.
  - 64 writes to addresses 0..63, all with slice_out=0x0000001.
  - done exactly 67 cycles after start; err=0.
- Round 23, slices preloaded with 0x1FFFFFF, line 24 = 0x1555555:
  - rc_line=24.
  - Every slice reads back 0x0AAAAAA.
  - Running the same round again restores 0x1FFFFFF.
- Illegal round=24:
  - done and err high one cycle after start.
  - No rc_ld and no slice_we at any point.
- Repeated start pulses while busy (cycles 5, 30, 66 after the first start):
  - Exactly one round executes with 64 writes and a single done pulse.
  - A start asserted in the cycle after done is accepted.

Source files
------------

// File: rtl/add_rc_slice_stage_if.sv
// add_rc_slice_stage_if: signals linking the iota stage to the round controller, RC reader and slice memory
// start/round: round request in; done/err/busy: status out
// rc_in/rc_ld/rc_line/rc_en_cnt: RC file reader link
// slice_addr/slice_in/slice_out/slice_we: slice memory port (asynchronous read)
interface add_rc_slice_stage_if #(parameter int N = 25, parameter int AW = 6);
   logic          start;
   logic [4:0]    round;
   logic [N-1:0]  rc_in;
   logic          rc_ld;
   logic [6:0]    rc_line;
   logic          rc_en_cnt;
   logic [AW-1:0] slice_addr;
   logic [N-1:0]  slice_in;
   logic [N-1:0]  slice_out;
   logic          slice_we;
   logic          busy;
   logic          done;
   logic          err;
   modport slave (
      input  start, round, rc_in, slice_in,
      output rc_ld, rc_line, rc_en_cnt, slice_addr, slice_out, slice_we, busy, done, err
   );
   modport master (
      output start, round, rc_in, slice_in,
      input  rc_ld, rc_line, rc_en_cnt, slice_addr, slice_out, slice_we, busy, done, err
   );
endinterface

// File: rtl/add_rc_slice_stage.sv
// add_rc_slice_stage: loads a round's RC mask from the reader and XORs it into every state slice
// clk: rising-edge clock; rst: asynchronous active-high reset
// bus (slave): start/round request, done/err/busy status, RC reader link, slice memory port
module add_rc_slice_stage #(
   parameter int N      = 25,
   parameter int SLICES = 64,
   parameter int ROUNDS = 24,
   parameter int AW     = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   add_rc_slice_stage_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, LOAD, WAIT, RUN, DONE} state_t;
   state_t        r_state, w_next;
   logic [4:0]    r_round;
   logic [N-1:0]  r_rc;
   logic [AW-1:0] r_addr;
   logic [6:0]    r_line;
   logic          r_err;
   logic          w_legal, w_last;
   assign w_legal = int'(bus.round) < ROUNDS;
   assign w_last  = r_addr == AW'(SLICES - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb
      w_next = r_state == IDLE ? (bus.start ? (w_legal ? LOAD : DONE) : IDLE) :
               r_state == LOAD ? WAIT :
               r_state == WAIT ? RUN :
               r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_round <= '0;
         r_rc    <= '0;
         r_addr  <= '0;
         r_line  <= '0;
         r_err   <= 1'b0;
      end else begin
         if (r_state == IDLE && bus.start) begin
            r_err <= !w_legal;
            if (w_legal) r_round <= bus.round;
         end
         if (r_state == LOAD) r_line <= 7'(r_round) + 7'd1;
         if (r_state == WAIT) r_rc <= bus.rc_in;
         // addr is already 0 on entry to RUN; it returns to 0 after the last slice
         if (r_state == RUN) r_addr <= w_last ? '0 : r_addr + AW'(1);
      end
   // rc_line must be valid during LOAD itself, so it is derived combinationally there
   // and held from the register elsewhere
   always_comb begin
      bus.rc_ld      = r_state == LOAD;
      bus.rc_line    = r_state == LOAD ? 7'(r_round) + 7'd1 : r_line;
      bus.rc_en_cnt  = r_state == RUN;
      bus.slice_we   = r_state == RUN;
      bus.slice_addr = r_addr;
      bus.slice_out  = bus.slice_in ^ r_rc;
      bus.busy       = r_state != IDLE;
      bus.done       = r_state == DONE;
      bus.err        = r_state == DONE && r_err;
   end
endmodule
